// File: rtl/spi_master_cfg_if.sv
// spi_master_cfg_if: command-side handshake plus SPI pin bundle for spi_master_cfg.
//
// Handshake: start is a one-cycle request that is taken only in a cycle where
// busy=0. The configuration and tx_data are sampled in that same cycle. busy
// rises on the next cycle and stays high until the cycle in which done pulses
// for exactly one cycle with rx_data valid. A request made while busy=1 is dropped.
interface spi_master_cfg_if #(
   parameter int DATA_W = 8,
   parameter int NUM_CS = 4,
   parameter int DIV_W  = 8
);
   localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

   logic              start;
   logic [DATA_W-1:0] tx_data;
   logic              cpol;
   logic              cpha;
   logic              lsb_first;
   logic [DIV_W-1:0]  clk_div;
   logic [CS_W-1:0]   cs_sel;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] rx_data;
   logic              sclk;
   logic              mosi;
   logic              miso;
   logic [NUM_CS-1:0] cs_n;

   // Core side: takes commands and MISO, drives status and SPI outputs
   modport master (
      input  start, tx_data, cpol, cpha, lsb_first, clk_div, cs_sel, miso,
      output busy, done, rx_data, sclk, mosi, cs_n
   );

   // Host/slave side: issues commands, observes status and pins
   modport slave (
      output start, tx_data, cpol, cpha, lsb_first, clk_div, cs_sel, miso,
      input  busy, done, rx_data, sclk, mosi, cs_n
   );
endinterface

// File: rtl/spi_master_cfg.sv
// spi_master_cfg: full-duplex SPI master with configurable word width, SPI mode,
// SCLK divider, bit order and chip select. One word per accepted start.
module spi_master_cfg #(
   parameter int DATA_W = 8,
   parameter int NUM_CS = 4,
   parameter int DIV_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   spi_master_cfg_if.master bus,
   output logic [1:0]       o_dbg_state
);
   localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
   localparam int EW   = $clog2(2 * DATA_W + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_XFER  = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   logic [1:0]        r_state;
   logic [DIV_W-1:0]  r_cnt;
   logic [DIV_W-1:0]  r_div;
   logic [EW-1:0]     r_edge;
   logic [DATA_W-1:0] r_tx;
   logic [DATA_W-1:0] r_rx;
   logic [DATA_W-1:0] r_rxd;
   logic              r_cpol;
   logic              r_cpha;
   logic              r_lsb;
   logic              r_busy;
   logic              r_done;
   logic              r_sclk;
   logic              r_mosi;
   logic [NUM_CS-1:0] r_cs_n;

   logic [NUM_CS-1:0] w_cs_dec;
   logic [EW-1:0]     w_edge_nxt;
   logic              w_sample;
   logic              w_last;
   logic              w_tx_bit;
   logic              w_first_bit;
   logic [DATA_W-1:0] w_tx_shift;
   logic [DATA_W-1:0] w_tx_load;
   logic [DATA_W-1:0] w_rx_shift;

   // One-hot select decode; an out-of-range cs_sel matches no line
   genvar g;
   generate
      for (g = 0; g < NUM_CS; g++) begin : g_cs_dec
         assign w_cs_dec[g] = (bus.cs_sel == CS_W'(g));
      end
   endgenerate

   // Edge classification and shift-path helpers
   always_comb begin
      w_edge_nxt  = r_edge + 1'b1;
      // Odd edges are leading; cpha flips which of the pair samples
      w_sample    = w_edge_nxt[0] ^ r_cpha;
      w_last      = (w_edge_nxt == EW'(2 * DATA_W));
      w_tx_bit    = r_lsb ? r_tx[0] : r_tx[DATA_W-1];
      w_tx_shift  = r_lsb ? (r_tx >> 1) : (r_tx << 1);
      w_rx_shift  = r_lsb ? {bus.miso, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], bus.miso};
      w_first_bit = bus.lsb_first ? bus.tx_data[0] : bus.tx_data[DATA_W-1];
      // cpha=0 puts the first bit on mosi at accept, so load the word already shifted
      if (bus.cpha) begin
         w_tx_load = bus.tx_data;
      end else begin
         w_tx_load = bus.lsb_first ? (bus.tx_data >> 1) : (bus.tx_data << 1);
      end
   end

   // Transfer sequencer: IDLE -> SETUP -> XFER -> HOLD -> IDLE, all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_div   <= '0;
         r_edge  <= '0;
         r_tx    <= '0;
         r_rx    <= '0;
         r_rxd   <= '0;
         r_cpol  <= 1'b0;
         r_cpha  <= 1'b0;
         r_lsb   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b0;
         r_cs_n  <= '1;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_sclk <= bus.cpol;
               if (bus.start) begin
                  r_cpol  <= bus.cpol;
                  r_cpha  <= bus.cpha;
                  r_lsb   <= bus.lsb_first;
                  r_div   <= bus.clk_div;
                  r_cnt   <= bus.clk_div;
                  r_edge  <= '0;
                  r_tx    <= w_tx_load;
                  r_rx    <= '0;
                  r_mosi  <= bus.cpha ? 1'b0 : w_first_bit;
                  r_cs_n  <= ~w_cs_dec;
                  r_busy  <= 1'b1;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP, S_XFER: begin
               if (r_cnt == '0) begin
                  r_cnt  <= r_div;
                  r_sclk <= ~r_sclk;
                  r_edge <= w_edge_nxt;
                  if (w_sample) begin
                     r_rx <= w_rx_shift;
                  end else if (!w_last) begin
                     // No bit follows the final trailing edge, so mosi holds there
                     r_mosi <= w_tx_bit;
                     r_tx   <= w_tx_shift;
                  end
                  r_state <= w_last ? S_HOLD : S_XFER;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_HOLD: begin
               if (r_cnt == '0) begin
                  r_rxd   <= r_rx;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_cs_n  <= '1;
                  r_mosi  <= 1'b0;
                  r_sclk  <= r_cpol;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.rx_data = r_rxd;
   assign bus.sclk    = r_sclk;
   assign bus.mosi    = r_mosi;
   assign bus.cs_n    = r_cs_n;
   assign o_dbg_state = r_state;
endmodule

// File: tb/tb_spi_master_cfg.sv
// tb_spi_master_cfg: directed bench for spi_master_cfg with an 8-bit/4-CS instance
// and a 16-bit/3-CS instance sharing one stimulus path and one SPI slave model.
module tb_spi_master_cfg;
   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- stimulus variables ----------------
   logic        start  = 1'b0;
   logic        cpol   = 1'b0;
   logic        cpha   = 1'b0;
   logic        lsb    = 1'b0;
   logic        miso   = 1'b0;
   logic        sel16  = 1'b0;
   logic [15:0] tx     = '0;
   logic [7:0]  div    = '0;
   logic [1:0]  cs_sel = '0;

   spi_master_cfg_if #(.DATA_W(8),  .NUM_CS(4), .DIV_W(8)) if8 ();
   spi_master_cfg_if #(.DATA_W(16), .NUM_CS(3), .DIV_W(8)) if16 ();
   logic [1:0] dbg8;
   logic [1:0] dbg16;

   spi_master_cfg #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .bus(if8.master), .o_dbg_state(dbg8)
   );
   spi_master_cfg #(.DATA_W(16), .NUM_CS(3), .DIV_W(8)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .bus(if16.master), .o_dbg_state(dbg16)
   );

   assign if8.start      = start & ~sel16;
   assign if8.tx_data    = tx[7:0];
   assign if8.cpol       = cpol;
   assign if8.cpha       = cpha;
   assign if8.lsb_first  = lsb;
   assign if8.clk_div    = div;
   assign if8.cs_sel     = cs_sel;
   assign if8.miso       = miso;
   assign if16.start     = start & sel16;
   assign if16.tx_data   = tx;
   assign if16.cpol      = cpol;
   assign if16.cpha      = cpha;
   assign if16.lsb_first = lsb;
   assign if16.clk_div   = div;
   assign if16.cs_sel    = cs_sel;
   assign if16.miso      = miso;

   // Observed view of whichever instance is selected
   logic        w_busy, w_done, w_sclk, w_mosi;
   logic [15:0] w_rx;
   logic [3:0]  w_cs_n;
   assign w_busy = sel16 ? if16.busy : if8.busy;
   assign w_done = sel16 ? if16.done : if8.done;
   assign w_sclk = sel16 ? if16.sclk : if8.sclk;
   assign w_mosi = sel16 ? if16.mosi : if8.mosi;
   assign w_rx   = sel16 ? if16.rx_data : {8'h00, if8.rx_data};
   assign w_cs_n = sel16 ? {1'b1, if16.cs_n} : if8.cs_n;

   // ---------------- checking ----------------
   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- SPI slave model ----------------
   int          s_w, s_idx, s_cap, s_edges, e_first, e_last, e_gap_bad;
   logic [15:0] s_tx, s_rx;
   logic        s_prev, s_first;

   function automatic logic s_bit(input int k);
      return lsb ? s_tx[k] : s_tx[s_w-1-k];
   endfunction

   task automatic slave_init(input int w, input logic [15:0] d);
      s_w = w; s_tx = d; s_rx = '0; s_idx = 0; s_cap = 0; s_edges = 0;
      e_first = 0; e_last = 0; e_gap_bad = 0; s_first = 1'b0; s_prev = cpol;
      if (!cpha) begin
         miso  = s_bit(0);
         s_idx = 1;
      end else begin
         miso = 1'b0;
      end
   endtask

   // Called once per cycle on the falling clk edge while a transfer runs
   task automatic slave_step(input int n, input int h);
      if (w_sclk !== s_prev) begin
         s_edges++;
         if (s_edges == 1) e_first = n;
         else if (n - e_last != h) e_gap_bad++;
         e_last = n;
         if ((((s_edges % 2) == 1) ? 1'b1 : 1'b0) ^ cpha) begin
            if (s_cap == 0) s_first = w_mosi;
            if (s_cap < s_w) begin
               s_rx[lsb ? s_cap : s_w-1-s_cap] = w_mosi;
               s_cap++;
            end
         end else if (s_idx < s_w) begin
            miso = s_bit(s_idx);
            s_idx++;
         end
      end
      s_prev = w_sclk;
   endtask

   // ---------------- driver ----------------
   task automatic run_xfer(input string tag, input bit w16, input logic [15:0] t,
                           input logic [15:0] srx, input bit pol, input bit pha,
                           input bit lsbf, input logic [7:0] d, input logic [1:0] cs,
                           input logic [3:0] exp_cs, input bit pre, input bit poke,
                           input bit chain);
      int w, h, n, lim, cs_bad, extra;
      w = w16 ? 16 : 8;
      h = int'(d) + 1;
      if (!pre) begin
         @(negedge clk);
         sel16 = w16; tx = t; cpol = pol; cpha = pha; lsb = lsbf; div = d; cs_sel = cs;
         slave_init(w, srx);
         start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      n = 1;
      check({tag, " busy_c1"}, 32'(w_busy), 32'd1);
      check({tag, " cs_c1"}, 32'(w_cs_n), 32'(exp_cs));
      check({tag, " sclk_idle"}, 32'(w_sclk), 32'(pol));
      lim = 1 + (2 * w + 1) * h + 20;
      cs_bad = 0;
      while (!w_done && n < lim) begin
         slave_step(n, h);
         if (w_cs_n !== exp_cs) cs_bad++;
         if (poke) start = (n == 5 || n == 10);
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check({tag, " done_cyc"}, 32'(n), 32'(1 + (2 * w + 1) * h));
      check({tag, " rx_data"}, 32'(w_rx), 32'(srx));
      check({tag, " slave_rx"}, 32'(s_rx), 32'(t));
      check({tag, " edges"}, 32'(s_edges), 32'(2 * w));
      check({tag, " first_edge"}, 32'(e_first), 32'(1 + h));
      check({tag, " last_edge"}, 32'(e_last), 32'(1 + 2 * w * h));
      check({tag, " edge_gap"}, 32'(e_gap_bad), 32'd0);
      check({tag, " cs_during"}, 32'(cs_bad), 32'd0);
      check({tag, " busy_done"}, 32'(w_busy), 32'd0);
      check({tag, " cs_done"}, 32'(w_cs_n), 32'hF);
      check({tag, " sclk_done"}, 32'(w_sclk), 32'(pol));
      check({tag, " mosi_done"}, 32'(w_mosi), 32'd0);
      if (chain) begin
         slave_init(w, srx);
         start = 1'b1;
         return;
      end
      @(negedge clk);
      check({tag, " done_pulse"}, 32'(w_done), 32'd0);
      if (poke) begin
         extra = 0;
         repeat (6) begin
            if (w_done || w_busy) extra++;
            @(negedge clk);
         end
         check({tag, " no_extra"}, 32'(extra), 32'd0);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      repeat (3) @(negedge clk);
      check("rst busy", 32'(if8.busy), 32'd0);
      check("rst done", 32'(if8.done), 32'd0);
      check("rst rx", 32'(if8.rx_data), 32'd0);
      check("rst sclk", 32'(if8.sclk), 32'd0);
      check("rst mosi", 32'(if8.mosi), 32'd0);
      check("rst cs8", 32'(if8.cs_n), 32'hF);
      check("rst cs16", 32'(if16.cs_n), 32'h7);
      check("rst state", 32'(dbg8), 32'd0);
      rst_n = 1'b1;

      // Reset asserted mid-transfer (cycle 9) discards the word
      @(negedge clk);
      sel16 = 1'b0; tx = 16'h003C; cpol = 0; cpha = 0; lsb = 0; div = 8'd0; cs_sel = 2'd0;
      slave_init(8, 16'h00A5);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      check("mid busy_pre", 32'(w_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid cs", 32'(w_cs_n), 32'hF);
      check("mid sclk", 32'(w_sclk), 32'd0);
      check("mid busy", 32'(w_busy), 32'd0);
      check("mid rx", 32'(w_rx), 32'd0);
      check("mid state", 32'(dbg8), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      //        tag     w16  tx        slave     pol cpha lsb div   cs    exp_cs   pre poke chain
      run_xfer("m0",    0, 16'h003C, 16'h00A5, 0, 0, 0, 8'd0, 2'd0, 4'b1110, 0, 0, 0);
      run_xfer("m3",    0, 16'h00C3, 16'h005A, 1, 1, 0, 8'd3, 2'd0, 4'b1110, 0, 0, 0);
      run_xfer("m1lsb", 0, 16'h0001, 16'h0080, 0, 1, 1, 8'd0, 2'd2, 4'b1011, 0, 0, 0);
      check("m1lsb first_mosi", 32'(s_first), 32'd1);
      run_xfer("w16",   1, 16'hBEEF, 16'h1234, 0, 0, 0, 8'd0, 2'd0, 4'b1110, 0, 0, 0);
      run_xfer("w16cs3",1, 16'h8001, 16'h7FFE, 1, 0, 0, 8'd1, 2'd3, 4'b1111, 0, 0, 0);
      run_xfer("poke",  0, 16'h0096, 16'h0069, 0, 0, 0, 8'd1, 2'd1, 4'b1101, 0, 1, 0);
      run_xfer("b2b_a", 0, 16'h00F0, 16'h000F, 0, 1, 0, 8'd0, 2'd3, 4'b0111, 0, 0, 1);
      run_xfer("b2b_b", 0, 16'h00F0, 16'h000F, 0, 1, 0, 8'd0, 2'd3, 4'b0111, 1, 0, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/spi_master_cfg.md
Name: spi_master_cfg

Overview:
- Parametrised successor to the fixed 8-bit, mode-0 SPI master.
- Supports configurable word width, all four SPI modes (CPOL/CPHA), a runtime SCLK divider, MSB/LSB-first ordering and up to NUM_CS chip selects.
- Sits between a register/command interface (start/busy/done handshake) and the SPI pins.
- Full-duplex: shifts tx_data out on mosi while capturing miso into rx_data.

Parameters:
- DATA_W, 8, bits per transfer (>=2).
- NUM_CS, 4, number of active-low chip-select lines (>=1).
- DIV_W, 8, width of the clk_div input.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle request; accepted only when busy=0.
- tx_data  in  DATA_W  word to transmit; latched on accept.
- cpol  in  1  SCLK idle level; latched on accept.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on accept.
- lsb_first  in  1  bit order; latched on accept.
- clk_div  in  DIV_W  SCLK half-period H = clk_div+1 clk cycles; latched on accept.
- cs_sel  in  $clog2(NUM_CS) (min 1)  target slave; latched on accept.
- busy  out  1  transfer in progress.
- done  out  1  1-cycle pulse at transfer end.
- rx_data  out  DATA_W  received word; updated only with done.
- sclk  out  1  SPI clock.
- mosi  out  1  master data out.
- miso  in  1  slave data in.
- cs_n  out  NUM_CS  chip selects, active low.

Behaviour:
- Reset (async, rst_n=0), effective immediately including mid-transfer:
  - busy=0, done=0, rx_data=0, sclk=0, mosi=0, cs_n=all 1s.
  - FSM returns to IDLE; the in-flight transfer is discarded and rx_data is not updated.
- FSM states: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
- IDLE:
  - sclk follows the registered cpol input.
  - start=1 at cycle 0 latches all configuration plus tx_data and moves to SETUP.
  - At cycle 1: busy=1 and cs_n[cs_sel]=0.
  - cs_sel >= NUM_CS: no cs_n line asserts, but the transfer still runs normally.
- SETUP:
  - Lasts H cycles.
  - If cpha=0, mosi presents the first bit from cycle 1.
- XFER:
  - Exactly 2*DATA_W SCLK edges, one every H cycles; first edge at cycle 1+H, last at cycle 1+2*DATA_W*H.
  - cpha=0: miso sampled on odd (leading) edges; next bit driven on even (trailing) edges.
  - cpha=1: bit driven on odd edges; miso sampled on even edges.
  - mosi is only changed on drive edges.
  - After the last edge, sclk equals the latched cpol.
- HOLD:
  - H cycles after the last edge (cycle 1+(2*DATA_W+1)*H): cs_n returns to all 1s, done=1 for one cycle, busy=0, rx_data takes the assembled word, mosi=0.
  - FSM returns to IDLE in that same cycle.
- Bit order:
  - lsb_first=0: tx bit DATA_W-1 is sent first; the first received bit lands in rx bit DATA_W-1.
  - lsb_first=1: bit 0 first in both directions.
- Handshake rules:
  - start while busy=1 is ignored, with no queueing.
  - start on the cycle done is high is accepted, giving a back-to-back transfer; CS still deasserts for at least 1 cycle.
  - Config input changes while busy have no effect.
- Divider: clk_div=0 gives H=1 (SCLK = clk/2). Max clk_div gives H=2^DIV_W. The internal counter must not overflow.
- Latency, start to done = 1+(2*DATA_W+1)*H cycles. DATA_W=8: 18 cycles at H=1, 35 cycles at H=2.
- miso is sampled raw, with no synchroniser; the slave is assumed to be in the SCLK domain with H >= 1.

Test Plan:
- DATA_W=8, mode 0, clk_div=0, cs_sel=0, tx_data=8'h3C, loopback slave model returning 8'hA5 -> slave captures 3C, rx_data=A5, done at cycle 18, cs_n=4'b1110 during transfer.
- Mode 3 (cpol=1, cpha=1), clk_div=3, tx_data=8'hC3, slave returns 8'h5A -> sclk idles 1, 16 edges spaced 4 cycles, rx_data=5A, done at cycle 69.
- lsb_first=1, mode 1, tx_data=8'h01, slave returns 8'h80 -> first mosi bit 1, rx_data=80; DATA_W=16 instance with tx 16'hBEEF exchanges 16'h1234 with 32 edges.
- Pulse start again at cycles 5 and 10 during a transfer -> ignored, exactly one done; start asserted on the done cycle -> second transfer starts, cs_n high for >= 1 cycle between.
- cs_sel=2 -> only cs_n[2] low; cs_sel=3 with NUM_CS=3 -> no cs_n asserts, done still pulses.
- rst_n low at cycle 9 of a transfer -> same cycle cs_n all 1, sclk=0, busy=0, rx_data unchanged at 0; next start completes normally.
